axis_frame_source_mem: RTL
==========================

Name: axis_frame_source_mem

Overview:
AXI-Stream master stimulus source for the systolic array tile and multi-tile benches. It is the parametrised successor of the memory-backed data generator.
- Streams beats from an internal loadable memory, split into fixed-length frames with TLAST on each frame's final beat.
- Supports programmable frame count, loop mode, pseudo-random valid throttling and a handshake beat counter.
- Synthesizable; usable on-board ahead of the array's S00_AXIS port.

Parameters:
C_M_AXIS_TDATA_WIDTH, 128, stream data width in bits; multiple of 8.
DATA_WIDTH, 9, element width; informational only (lane packing is the loader's concern).
MEM_DEPTH, 256, beats of storage; power of 2; ADDR_W = log2(MEM_DEPTH).
FRAME_LEN, 32, beats per frame; >= 1.
C_M_START_COUNT, 32, idle cycles between start and streaming; >= 1.
LFSR_SEED, 16'hACE1, throttle LFSR reset value; nonzero.

Ports:
m00_axis_aclk  in  1  clock
m00_axis_aresetn  in  1  asynchronous active-low reset
cfg_wr_en  in  1  memory write strobe
cfg_wr_addr  in  ADDR_W  memory write address
cfg_wr_data  in  C_M_AXIS_TDATA_WIDTH  memory write data
start  in  1  begin a run; level sampled, acted on only in IDLE
num_frames  in  16  frames per run; sampled on start
loop_mode  in  1  repeat run while high
throttle  in  1  enable LFSR-gated beat insertion
busy  out  1  high from accepted start until run completes
done  out  1  one-cycle pulse at run completion
beat_count  out  32  accepted beats since last start; wraps
m00_axis_tvalid  out  1  AXIS valid
m00_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  AXIS data
m00_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  constant all-ones
m00_axis_tlast  out  1  last beat of frame
m00_axis_tready  in  1  AXIS ready

Behaviour:
- Reset (async assert, sync release): tvalid, tlast, tdata, busy and done = 0; beat_count = 0; rd_ptr, frame and beat counters = 0; LFSR = LFSR_SEED; state = IDLE. Memory is not reset and its contents survive reset.
- Memory: cfg_wr_en writes mem[cfg_wr_addr] at the clock edge, only in IDLE. Writes while busy are ignored.
- State IDLE:
  - start=1 with num_frames=0: done pulses the next cycle; busy stays 0; no beats are sent.
  - start=1 with num_frames>0: latch num_frames; rd_ptr = 0; beat_count = 0; busy = 1; go to WAIT.
- State WAIT: count C_M_START_COUNT cycles, then go to STREAM. With start sampled at edge k, tvalid first rises after edge k+C_M_START_COUNT+1 (when not throttled).
- State STREAM, output register stage:
  - Load condition: (!tvalid || tready) and beats remain and no gap this cycle.
  - On load: tdata <= mem[rd_ptr]; tlast <= (beat_in_frame == FRAME_LEN-1); tvalid <= 1; rd_ptr increments.
  - Otherwise, if tready: tvalid <= 0.
  - With tready held 1 and no throttle, back-to-back beats are sent at one per cycle.
- AXIS rules: once tvalid is high, tdata and tlast hold stable until tready. tvalid never drops without a handshake.
- rd_ptr wraps from MEM_DEPTH-1 to 0. beat_in_frame wraps from FRAME_LEN-1 to 0 and increments the frame counter.
- Throttle: the 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in every state. When throttle=1 and lfsr[0]=1, a gap is inserted: no new beat loads that cycle. An already-valid beat is unaffected.
- Completion: evaluated on the handshake of the final frame's tlast beat.
  - loop_mode=1: frame counter and rd_ptr reset to 0; streaming continues with no bubble attributable to the restart.
  - loop_mode=0: state goes to IDLE, busy drops and done pulses, all on the cycle after the handshake.
- beat_count increments on every tvalid && tready handshake.
- start while busy is ignored.
- Reset mid-run: the stream aborts immediately with tvalid = 0. No partial frame is resumed after reset.

Test Plan:
1. mem[i] = i for i in 0..63; num_frames=2; tready=1 -> 64 beats with data 0..63 in order; tlast on beats 31 and 63; first tvalid at start+33 cycles; done 1 cycle after beat 63; beat_count=64.
2. Same load; tready alternating 1/0 -> identical sequence; tdata and tlast stable whenever tvalid && !tready; tvalid never drops unaccepted.
3. num_frames=0 -> done pulses on the cycle after start; busy stays 0; tvalid stays 0.
4. num_frames=10 (320 beats), MEM_DEPTH=256 -> beat 256 carries mem[0]; tlast every 32nd beat; beat_count=320.
5. throttle=1, tready=1, num_frames=2 -> at least one gap cycle; exactly 64 beats; data order 0..63. Repeat with loop_mode=1 for 3 passes, then drop it -> 192 beats and a single done.
6. Assert m00_axis_aresetn at beat 10 -> tvalid, busy, tlast and beat_count read 0 before the next edge. Release and start again -> stream restarts at mem[0] with the memory contents intact.

Source files
------------

// File: rtl/axis_frame_source_mem.sv
// AXI-Stream frame source: streams beats from a loadable memory in fixed-length
// frames with TLAST, with optional looping and LFSR-driven valid throttling.
module axis_frame_source_mem #(
  parameter int          C_M_AXIS_TDATA_WIDTH = 128,
  parameter int          DATA_WIDTH           = 9,
  parameter int          MEM_DEPTH            = 256,
  parameter int          FRAME_LEN            = 32,
  parameter int          C_M_START_COUNT      = 32,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_aresetn,
  input  logic                              cfg_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0]      cfg_wr_addr,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   cfg_wr_data,
  input  logic                              start,
  input  logic [15:0]                       num_frames,
  input  logic                              loop_mode,
  input  logic                              throttle,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       beat_count,
  output logic                              m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int FL_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;
  localparam logic [31:0]     WAIT_LAST = 32'(C_M_START_COUNT - 1);
  localparam logic [FL_W-1:0] BEAT_LAST = FL_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t state_reg, state_next;

  logic [C_M_AXIS_TDATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0]               rd_ptr_reg;
  logic [FL_W-1:0]                 beat_in_frame_reg;
  logic [15:0]                     frame_reg;
  logic [15:0]                     num_frames_reg;
  logic [31:0]                     wait_cnt_reg;
  logic [15:0]                     lfsr_reg;
  logic [31:0]                     beat_count_reg;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_reg;
  logic                            tvalid_reg;
  logic                            tlast_reg;
  logic                            busy_reg;
  logic                            done_reg;
  logic                            more_reg;   // producer still has beats to load
  logic                            final_reg;  // beat in the output stage ends the run

  logic start_run;
  logic start_empty;
  logic load;
  logic finish;
  logic handshake;
  logic gap;
  logic frame_end;
  logic run_end;
  logic lfsr_fb;

  assign handshake = tvalid_reg && m00_axis_tready;
  assign gap       = throttle && lfsr_reg[0];
  assign frame_end = (beat_in_frame_reg == BEAT_LAST);
  assign run_end   = frame_end && (frame_reg == num_frames_reg - 16'd1);
  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_run   = 1'b0;
    start_empty = 1'b0;
    load        = 1'b0;
    finish      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (num_frames == 16'd0) begin
            start_empty = 1'b1;
          end else begin
            start_run  = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        load = (!tvalid_reg || m00_axis_tready) && more_reg && !gap;
        if (handshake && final_reg) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Storage has no reset so contents survive a reset; loading only while idle.
  always_ff @(posedge m00_axis_aclk) begin
    if (cfg_wr_en && state_reg == S_IDLE) begin
      mem[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      rd_ptr_reg        <= '0;
      beat_in_frame_reg <= '0;
      frame_reg         <= '0;
      num_frames_reg    <= '0;
      wait_cnt_reg      <= '0;
      lfsr_reg          <= LFSR_SEED;
      beat_count_reg    <= '0;
      tdata_reg         <= '0;
      tvalid_reg        <= 1'b0;
      tlast_reg         <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      more_reg          <= 1'b0;
      final_reg         <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      done_reg <= start_empty || finish;

      if (start_run) begin
        beat_count_reg <= '0;
      end else if (handshake) begin
        beat_count_reg <= beat_count_reg + 32'd1;
      end

      if (start_run) begin
        busy_reg <= 1'b1;
      end else if (finish) begin
        busy_reg <= 1'b0;
      end

      if (start_run) begin
        num_frames_reg    <= num_frames;
        rd_ptr_reg        <= '0;
        beat_in_frame_reg <= '0;
        frame_reg         <= '0;
        wait_cnt_reg      <= '0;
        more_reg          <= 1'b1;
        final_reg         <= 1'b0;
      end else if (state_reg == S_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 32'd1;
      end else if (load) begin
        tdata_reg  <= mem[rd_ptr_reg];
        tlast_reg  <= frame_end;
        tvalid_reg <= 1'b1;
        final_reg  <= run_end && !loop_mode;
        // Looping rewinds on the load of the last beat so the next pass follows without a bubble.
        if (run_end) begin
          rd_ptr_reg        <= '0;
          beat_in_frame_reg <= '0;
          frame_reg         <= '0;
          if (!loop_mode) begin
            more_reg <= 1'b0;
          end
        end else begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (frame_end) begin
            beat_in_frame_reg <= '0;
            frame_reg         <= frame_reg + 16'd1;
          end else begin
            beat_in_frame_reg <= beat_in_frame_reg + 1'b1;
          end
        end
      end else if (handshake) begin
        tvalid_reg <= 1'b0;
        tlast_reg  <= 1'b0;
        final_reg  <= 1'b0;
      end
    end
  end

  // Every byte lane is always valid regardless of the element width.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign m00_axis_tstrb[gi] = (DATA_WIDTH > 0);
    end
  endgenerate

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign beat_count      = beat_count_reg;
  assign m00_axis_tvalid = tvalid_reg;
  assign m00_axis_tdata  = tdata_reg;
  assign m00_axis_tlast  = tlast_reg;

endmodule
